// File: rtl/ball_collision.sv
// Ball collision detector: wall/paddle contact, crash pulses with per-axis holdoff,
// miss tracking, scores and game-over latch.
module ball_collision #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int WALL_MARGIN = 2,
    parameter int PADDLE_L_X  = 16,
    parameter int PADDLE_R_X  = 616,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int HOLDOFF     = 4,
    parameter int SCORE_MAX   = 9
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic [9:0] iBall_x,
    input  logic [9:0] iBall_y,
    input  logic [9:0] iPaddleL_y,
    input  logic [9:0] iPaddleR_y,
    output logic [3:0] oCrash,
    output logic       oMiss,
    output logic [3:0] oScoreL,
    output logic [3:0] oScoreR,
    output logic       oGameOver
);

    // state     | meaning
    // PLAY      | normal detection, misses score
    // MISS_HOLD | a miss just scored; further misses ignored for HOLDOFF cycles
    // OVER      | a score reached SCORE_MAX; scores frozen, bouncing continues
    typedef enum logic [1:0] {PLAY, MISS_HOLD, OVER} state_t;

    localparam logic [10:0] L_WM     = 11'(WALL_MARGIN);
    localparam logic [10:0] L_BS     = 11'(BALL_SIZE);
    localparam logic [10:0] L_DOWN   = 11'(SCREEN_H - WALL_MARGIN);
    localparam logic [10:0] L_RWALL  = 11'(SCREEN_W - WALL_MARGIN);
    localparam logic [10:0] L_PLX    = 11'(PADDLE_L_X);
    localparam logic [10:0] L_PL_END = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] L_PRX    = 11'(PADDLE_R_X);
    localparam logic [10:0] L_PR_END = 11'(PADDLE_R_X + PADDLE_W);
    localparam logic [10:0] L_PH     = 11'(PADDLE_H);
    localparam logic [10:0] L_UF     = 11'd1000;
    localparam logic [3:0]  L_HOLD   = 4'(HOLDOFF);
    localparam logic [3:0]  L_SMAX   = 4'(SCORE_MAX);

    state_t     state;
    logic [3:0] hold_x, hold_y, miss_cnt;

    logic [10:0] x11, y11, pl11, pr11;
    logic ux, uy, up_c, down_c, vert_l, vert_r, hit_l, hit_r, wall_l, wall_r;
    logic crash_l, crash_r, crash_u, crash_d, miss_l, miss_r;

    // Sums are 11 bits so ball+size and paddle+height never wrap.
    always_comb begin
        x11     = {1'b0, iBall_x};
        y11     = {1'b0, iBall_y};
        pl11    = {1'b0, iPaddleL_y};
        pr11    = {1'b0, iPaddleR_y};
        ux      = x11 >= L_UF;
        uy      = y11 >= L_UF;
        up_c    = (y11 <= L_WM) || uy;
        down_c  = (y11 + L_BS >= L_DOWN) && !uy;
        vert_l  = (y11 + L_BS > pl11) && (y11 < pl11 + L_PH);
        vert_r  = (y11 + L_BS > pr11) && (y11 < pr11 + L_PH);
        hit_l   = (x11 <= L_PL_END) && (x11 + L_BS > L_PLX) && vert_l;
        hit_r   = (x11 + L_BS >= L_PRX) && (x11 < L_PR_END) && vert_r;
        wall_l  = (x11 <= L_WM) || ux;
        wall_r  = x11 + L_BS >= L_RWALL;
        crash_l = (hold_x == 4'd0) && (hit_l || wall_l);
        crash_r = (hold_x == 4'd0) && !(hit_l || wall_l) && (hit_r || wall_r);
        crash_u = (hold_y == 4'd0) && up_c;
        crash_d = (hold_y == 4'd0) && !up_c && down_c;
        miss_l  = crash_l && !hit_l;
        miss_r  = crash_r && !hit_r;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= PLAY;
            hold_x    <= 4'd0;
            hold_y    <= 4'd0;
            miss_cnt  <= 4'd0;
            oCrash    <= 4'd0;
            oMiss     <= 1'b0;
            oScoreL   <= 4'd0;
            oScoreR   <= 4'd0;
            oGameOver <= 1'b0;
        end else begin
            oCrash <= {crash_l, crash_r, crash_u, crash_d};
            oMiss  <= 1'b0;

            if (crash_l || crash_r)    hold_x <= L_HOLD;
            else if (hold_x != 4'd0)   hold_x <= hold_x - 4'd1;

            if (crash_u || crash_d)    hold_y <= L_HOLD;
            else if (hold_y != 4'd0)   hold_y <= hold_y - 4'd1;

            case (state)
                PLAY: begin
                    if (miss_l || miss_r) begin
                        oMiss    <= 1'b1;
                        miss_cnt <= L_HOLD;
                        state    <= (L_HOLD == 4'd0) ? PLAY : MISS_HOLD;
                        if (miss_l && oScoreR < L_SMAX) begin
                            oScoreR <= oScoreR + 4'd1;
                            if (oScoreR + 4'd1 == L_SMAX) begin
                                state     <= OVER;
                                oGameOver <= 1'b1;
                            end
                        end
                        if (miss_r && oScoreL < L_SMAX) begin
                            oScoreL <= oScoreL + 4'd1;
                            if (oScoreL + 4'd1 == L_SMAX) begin
                                state     <= OVER;
                                oGameOver <= 1'b1;
                            end
                        end
                    end
                end
                MISS_HOLD: begin
                    if (miss_cnt <= 4'd1) begin
                        miss_cnt <= 4'd0;
                        state    <= PLAY;
                    end else begin
                        miss_cnt <= miss_cnt - 4'd1;
                    end
                end
                OVER: begin
                    oGameOver <= 1'b1;
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_collision.sv
// Bench for ball_collision: directed plan steps plus randomized positions against
// a cycle-count based reference model of crash, miss and score behaviour.
module tb_ball_collision;

    localparam int HOLDOFF   = 4;
    localparam int SCORE_MAX = 9;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n;
    logic [9:0] iBall_x, iBall_y, iPaddleL_y, iPaddleR_y;
    logic [3:0] oCrash, oScoreL, oScoreR;
    logic       oMiss, oGameOver;

    ball_collision dut (
        .iVGA_CLK   (iVGA_CLK),
        .iRST_n     (iRST_n),
        .iBall_x    (iBall_x),
        .iBall_y    (iBall_y),
        .iPaddleL_y (iPaddleL_y),
        .iPaddleR_y (iPaddleR_y),
        .oCrash     (oCrash),
        .oMiss      (oMiss),
        .oScoreL    (oScoreL),
        .oScoreR    (oScoreR),
        .oGameOver  (oGameOver)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: remembers the cycle of the last x/y pulse and last scored miss.
    int cyc, last_xp, last_yp, last_miss, m_scl, m_scr;
    bit m_over;
    logic [3:0] e_crash;
    logic       e_miss;

    int xs[18] = '{0, 2, 3, 8, 15, 16, 24, 25, 300, 607, 608, 616, 623, 624, 630, 632, 1000, 1023};
    int ys[11] = '{0, 2, 3, 50, 100, 469, 470, 472, 999, 1000, 1022};

    task automatic model_reset();
        cyc = 0; last_xp = -100; last_yp = -100; last_miss = -100;
        m_scl = 0; m_scr = 0; m_over = 0; e_crash = 4'd0; e_miss = 1'b0;
    endtask

    task automatic model_step();
        int x, y, pl, pr;
        bit ux, uy, up, down, hl, hr, wl, wr, ml, mr;
        x = int'(iBall_x); y = int'(iBall_y); pl = int'(iPaddleL_y); pr = int'(iPaddleR_y);
        ux   = x >= 1000;
        uy   = y >= 1000;
        up   = (y <= 2) || uy;
        down = (y + 8 >= 478) && !uy;
        hl   = (x <= 24) && (x + 8 > 16) && (y + 8 > pl) && (y < pl + 64);
        hr   = (x + 8 >= 616) && (x < 624) && (y + 8 > pr) && (y < pr + 64);
        wl   = (x <= 2) || ux;
        wr   = x + 8 >= 638;
        e_crash = 4'd0; e_miss = 1'b0; ml = 0; mr = 0;
        if (cyc - last_xp > HOLDOFF) begin
            if (hl || wl) begin e_crash[3] = 1'b1; last_xp = cyc; ml = !hl; end
            else if (hr || wr) begin e_crash[2] = 1'b1; last_xp = cyc; mr = !hr; end
        end
        if (cyc - last_yp > HOLDOFF) begin
            if (up) begin e_crash[1] = 1'b1; last_yp = cyc; end
            else if (down) begin e_crash[0] = 1'b1; last_yp = cyc; end
        end
        if ((ml || mr) && !m_over && (cyc - last_miss > HOLDOFF)) begin
            e_miss = 1'b1;
            last_miss = cyc;
            if (ml) m_scr++; else m_scl++;
            if (m_scl == SCORE_MAX || m_scr == SCORE_MAX) m_over = 1;
        end
        cyc++;
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check4({tag, ".crash"}, oCrash, e_crash);
        check4({tag, ".miss"}, {3'd0, oMiss}, {3'd0, e_miss});
        check4({tag, ".scoreL"}, oScoreL, 4'(m_scl));
        check4({tag, ".scoreR"}, oScoreR, 4'(m_scr));
        check4({tag, ".over"}, {3'd0, oGameOver}, {3'd0, m_over});
    endtask

    task automatic step(input int x, input int y, input int pl, input int pr, input string tag);
        iBall_x = 10'(x); iBall_y = 10'(y); iPaddleL_y = 10'(pl); iPaddleR_y = 10'(pr);
        @(posedge iVGA_CLK);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(300, 100, 200, 200, "idle");
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(posedge iVGA_CLK);
        #1;
        iRST_n = 1'b1;
    endtask

    initial begin
        iBall_x = 10'd300; iBall_y = 10'd100; iPaddleL_y = 10'd200; iPaddleR_y = 10'd200;
        iRST_n = 1'b1;
        #1;
        do_reset();

        // Left paddle hit held 8 cycles: pulse, 4 suppressed, pulse again
        for (int i = 0; i < 8; i++) begin
            step(24, 100, 80, 200, "lpaddle");
            if (i == 0) check4("lpaddle_first", oCrash, 4'b1000);
            if (i == 5) check4("lpaddle_again", oCrash, 4'b1000);
        end
        idle(6);

        // Left miss held 4 cycles: single increment
        for (int i = 0; i < 4; i++) step(2, 100, 300, 200, "lmiss");
        check4("lmiss_scoreR", oScoreR, 4'd1);
        idle(6);

        step(300, 2, 200, 200, "wall_up");
        check4("wall_up_v", oCrash, 4'b0010);
        idle(6);
        step(300, 472, 200, 200, "wall_down");
        check4("wall_down_v", oCrash, 4'b0001);
        idle(6);
        step(300, 1022, 200, 200, "wall_uflow");
        check4("wall_uflow_v", oCrash, 4'b0010);
        idle(6);

        step(24, 2, 0, 200, "corner");
        check4("corner_v", oCrash, 4'b1010);
        idle(6);

        // Game over after 9 right-wall misses
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(632, 100, 200, 300, "rwall");
            idle(5);
        end
        check4("over_scoreL", oScoreL, 4'd9);
        check4("over_flag", {3'd0, oGameOver}, 4'd1);
        step(632, 100, 200, 300, "rwall10");
        check4("rwall10_crash", oCrash, 4'b0100);
        check4("rwall10_miss", {3'd0, oMiss}, 4'd0);
        check4("rwall10_score", oScoreL, 4'd9);
        idle(6);

        // Reset in the middle of holdoff
        do_reset();
        for (int i = 0; i < 3; i++) step(24, 100, 80, 200, "prerst");
        do_reset();
        step(24, 100, 80, 200, "postrst");
        check4("postrst_pulse", oCrash, 4'b1000);
        idle(6);

        // Randomized positions, each held 1-3 cycles
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int x, y, pl, pr, hold;
            x    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : xs[$urandom_range(0, 17)];
            y    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : ys[$urandom_range(0, 10)];
            pl   = ($urandom_range(0, 1) == 0) ? (y > 30 ? y - 30 : 0) : int'($urandom_range(0, 460));
            pr   = ($urandom_range(0, 1) == 0) ? (y > 30 ? y - 30 : 0) : int'($urandom_range(0, 460));
            hold = int'($urandom_range(1, 3));
            for (int h = 0; h < hold; h++) step(x, y, pl, pr, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
